// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the bus-controller responder (bus_ctrl_resp) and
// its MMIO register block (bc_mmio_regs):
//   - bc_state_t     : responder FSM state encoding
//   - OFS_*          : MMIO register byte offsets inside the 16-byte window
//   - ERRCNT_W/LED_W : widths of the error counter and the LED register
// ---------------------------------------------------------------------------
package bc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEM  = 3'd1,
        ST_REG  = 3'd2,
        ST_RESP = 3'd3,
        ST_GAP  = 3'd4
    } bc_state_t;

    localparam logic [3:0] OFS_LED    = 4'h0;
    localparam logic [3:0] OFS_TIMER  = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;

    localparam int ERRCNT_W = 8;
    localparam int LED_W    = 16;

endpackage : bc_pkg

// File: rtl/bc_mmio_regs.sv
// ---------------------------------------------------------------------------
// bc_mmio_regs
// MMIO register block of the bus-controller responder.
//   0x0 LED    : RW, 16 bits
//   0x4 TIMER  : free-running 32-bit counter; any write clears it to 0
//   0x8 STATUS : RO, saturating 8-bit error counter
//   0xC        : reserved, reads 0
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr        : write strobe (one cycle), qualified by offset
//   offset    : byte offset inside the MMIO window
//   wdata     : write data (only the LED register consumes a value)
//   err_pulse : one-cycle pulse per errored response; bumps the counter
//   rdata     : combinational read mux for the current offset
//   led       : LED register contents
// ---------------------------------------------------------------------------
module bc_mmio_regs
    import bc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [3:0]       offset,
    input  logic [LED_W-1:0] wdata,
    input  logic             err_pulse,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led
);

    logic [LED_W-1:0]    led_reg;
    logic [31:0]         timer_reg;
    logic [ERRCNT_W-1:0] errcnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
        end else if (wr && (offset == OFS_LED)) begin
            led_reg <= wdata;
        end
    end

    // Wraps naturally at 2^32; a write clears and wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (wr && (offset == OFS_TIMER)) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 32'd1;
        end
    end

    // Saturates at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt_reg <= '0;
        end else if (err_pulse && (errcnt_reg != '1)) begin
            errcnt_reg <= errcnt_reg + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFS_LED:    rdata = {{(32-LED_W){1'b0}}, led_reg};
            OFS_TIMER:  rdata = timer_reg;
            OFS_STATUS: rdata = {{(32-ERRCNT_W){1'b0}}, errcnt_reg};
            default:    rdata = '0;
        endcase
    end

    assign led = led_reg;

endmodule : bc_mmio_regs

// File: rtl/bus_ctrl_resp.sv
// ---------------------------------------------------------------------------
// bus_ctrl_resp
// Bus-controller responder between the CPU memory stage and the data RAM.
// Decodes each CPU request into the data-memory window, the 16-byte MMIO
// window at MMIO_BASE, or unmapped space; runs the access and returns a
// one-cycle ready pulse with read data and an error qualifier. Every
// response is followed by one idle (GAP) cycle.
//
// Optional feature (macro BC_TIMEOUT_EN): a MEM-state watchdog aborts the
// access with err = 1 when mem_ack is missing for TIMEOUT cycles. Without
// the macro the TIMEOUT parameter and the counter do not exist.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cpu_bc_req/addr/data/rw  : CPU request (held until bc_cpu_ready)
//   bc_cpu_data/ready/err    : registered response, valid with ready
//   mem_en/we/addr/wdata     : registered data-RAM request
//   mem_rdata, mem_ack       : data-RAM response
//   led                      : LED register contents
// ---------------------------------------------------------------------------
module bus_ctrl_resp
    import bc_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
`ifdef BC_TIMEOUT_EN
    ,
    parameter int          TIMEOUT   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_bc_req,
    input  logic [31:0]       cpu_bc_addr,
    input  logic [31:0]       cpu_bc_data,
    input  logic              cpu_bc_rw,
    output logic [31:0]       bc_cpu_data,
    output logic              bc_cpu_ready,
    output logic              bc_cpu_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [LED_W-1:0]  led
);

    // 33-bit limits so the window ends never overflow the compare.
    localparam logic [32:0] MEM_END  = 33'(1) << (MEM_AW + 2);
    localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'd16;

    bc_state_t         state_reg, state_next;
    logic              mem_en_reg, mem_en_next;
    logic              mem_we_reg, mem_we_next;
    logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic              ready_reg, ready_next;
    logic              err_reg, err_next;
    logic [31:0]       data_reg, data_next;
    logic [3:0]        ofs_reg, ofs_next;
    logic              reg_rw_reg, reg_rw_next;
    logic [LED_W-1:0]  reg_wdata_reg, reg_wdata_next;

    logic              in_mem;
    logic              in_mmio;
    logic              regs_wr;
    logic [31:0]       regs_rdata;

`ifdef BC_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
`endif

    assign in_mem  = ({1'b0, cpu_bc_addr} < MEM_END);
    assign in_mmio = (cpu_bc_addr >= MMIO_BASE) && ({1'b0, cpu_bc_addr} < MMIO_END);

    always_comb begin
        state_next     = state_reg;
        mem_en_next    = mem_en_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ofs_next       = ofs_reg;
        reg_rw_next    = reg_rw_reg;
        reg_wdata_next = reg_wdata_reg;
        ready_next     = 1'b0;
        err_next       = 1'b0;
        data_next      = '0;
        regs_wr        = 1'b0;
`ifdef BC_TIMEOUT_EN
        tcnt_next      = '0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (cpu_bc_req) begin
                    if (cpu_bc_addr[1:0] != 2'b00) begin
                        state_next = ST_RESP;
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                    end else if (in_mem) begin
                        state_next     = ST_MEM;
                        mem_en_next    = 1'b1;
                        mem_we_next    = cpu_bc_rw;
                        mem_addr_next  = cpu_bc_addr[MEM_AW+1:2];
                        mem_wdata_next = cpu_bc_data;
                    end else if (in_mmio) begin
                        state_next     = ST_REG;
                        ofs_next       = cpu_bc_addr[3:0];
                        reg_rw_next    = cpu_bc_rw;
                        reg_wdata_next = cpu_bc_data[LED_W-1:0];
                    end else begin
                        state_next = ST_RESP;
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end

            ST_MEM: begin
                if (mem_ack) begin
                    state_next  = ST_RESP;
                    ready_next  = 1'b1;
                    data_next   = mem_we_reg ? 32'd0 : mem_rdata;
                    mem_en_next = 1'b0;
                    mem_we_next = 1'b0;
`ifdef BC_TIMEOUT_EN
                end else if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
                    state_next  = ST_RESP;
                    ready_next  = 1'b1;
                    err_next    = 1'b1;
                    mem_en_next = 1'b0;
                    mem_we_next = 1'b0;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
`endif
                end
            end

            // The write lands on the same edge that captures the read mux,
            // so a read of the register being written returns the old value.
            ST_REG: begin
                state_next = ST_RESP;
                ready_next = 1'b1;
                data_next  = reg_rw_reg ? 32'd0 : regs_rdata;
                regs_wr    = reg_rw_reg;
            end

            ST_RESP: state_next = ST_GAP;

            ST_GAP:  state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ready_reg     <= 1'b0;
            err_reg       <= 1'b0;
            data_reg      <= '0;
            ofs_reg       <= '0;
            reg_rw_reg    <= 1'b0;
            reg_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            ready_reg     <= ready_next;
            err_reg       <= err_next;
            data_reg      <= data_next;
            ofs_reg       <= ofs_next;
            reg_rw_reg    <= reg_rw_next;
            reg_wdata_reg <= reg_wdata_next;
        end
    end

`ifdef BC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_next;
        end
    end
`endif

    // Error counter bumps during the RESP cycle of an errored response.
    bc_mmio_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr        (regs_wr),
        .offset    (ofs_reg),
        .wdata     (reg_wdata_reg),
        .err_pulse (ready_reg & err_reg),
        .rdata     (regs_rdata),
        .led       (led)
    );

    assign bc_cpu_data  = data_reg;
    assign bc_cpu_ready = ready_reg;
    assign bc_cpu_err   = err_reg;
    assign mem_en       = mem_en_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule : bus_ctrl_resp

// File: tb/tb_bus_ctrl_resp.sv
// ---------------------------------------------------------------------------
// tb_bus_ctrl_resp
// Directed testbench for bus_ctrl_resp with a small data-RAM responder.
// Latency "lat" = number of falling edges from request drive until ready is
// seen: 1 for decode errors, 2 for MMIO, ack_delay+2 for memory accesses.
// ---------------------------------------------------------------------------
module tb_bus_ctrl_resp;

    localparam int MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_bc_req = 1'b0;
    logic [31:0]       cpu_bc_addr = '0;
    logic [31:0]       cpu_bc_data = '0;
    logic              cpu_bc_rw = 1'b0;
    logic [31:0]       bc_cpu_data;
    logic              bc_cpu_ready;
    logic              bc_cpu_err;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [15:0]       led;

    int n_vec  = 0;
    int n_miss = 0;

    // RAM responder controls and observations
    logic              ack_enable = 1'b1;
    int                ack_delay  = 0;
    logic [31:0]       rd_value   = '0;
    int                wait_cnt   = 0;
    int                mem_en_cycles = 0;
    logic [MEM_AW-1:0] obs_addr  = '0;
    logic              obs_we    = 1'b0;
    logic [31:0]       obs_wdata = '0;

    bus_ctrl_resp #(
        .MEM_AW    (MEM_AW),
        .MMIO_BASE (32'hFFFF_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_bc_req   (cpu_bc_req),
        .cpu_bc_addr  (cpu_bc_addr),
        .cpu_bc_data  (cpu_bc_data),
        .cpu_bc_rw    (cpu_bc_rw),
        .bc_cpu_data  (bc_cpu_data),
        .bc_cpu_ready (bc_cpu_ready),
        .bc_cpu_err   (bc_cpu_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .led          (led)
    );

    always #5 clk = ~clk;

    // Acks ack_delay falling edges after mem_en is first seen; one-cycle ack.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) mem_en_cycles++;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_en && ack_enable) begin
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_value;
                    obs_addr  = mem_addr;
                    obs_we    = mem_we;
                    obs_wdata = mem_wdata;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        cpu_bc_req  = 1'b1;
        cpu_bc_addr = addr;
        cpu_bc_rw   = rw;
        cpu_bc_data = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bc_cpu_ready && lat < 200);
        check("ready_seen", 32'(bc_cpu_ready), 32'd1);
        rdata = bc_cpu_data;
        err   = bc_cpu_err;
        cpu_bc_req = 1'b0;
        cpu_bc_rw  = 1'b0;
        @(negedge clk);
        check("ready_single", 32'(bc_cpu_ready), 32'd0);
        check("mem_en_after", 32'(mem_en), 32'd0);
        $display("xfer addr=0x%08h rw=%0d wdata=0x%08h -> data=0x%08h err=%0d lat=%0d",
                 addr, rw, wdata, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          en_before;
        int          n_ready;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp", {bc_cpu_data[29:0], bc_cpu_ready, bc_cpu_err}, 32'd0);
        check("rst_mem", {19'd0, mem_en, mem_we, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst = 1'b0;

        // Memory read, ack two cycles into MEM
        ack_delay = 2;
        rd_value  = 32'hDEAD_BEEF;
        xfer(32'h0000_0010, 1'b0, 32'd0, rd, er, lat);
        check("memrd_data", rd, 32'hDEAD_BEEF);
        check("memrd_err", 32'(er), 32'd0);
        check("memrd_lat", 32'(lat), 32'd4);
        check("memrd_addr", 32'(obs_addr), 32'd4);
        check("memrd_we", 32'(obs_we), 32'd0);

        // Memory write at the last word of the window, ack in first MEM cycle
        ack_delay = 0;
        rd_value  = 32'hCAFE_F00D;
        xfer(32'h0000_3FFC, 1'b1, 32'h1234_5678, rd, er, lat);
        check("memwr_data", rd, 32'd0);
        check("memwr_err", 32'(er), 32'd0);
        check("memwr_lat", 32'(lat), 32'd2);
        check("memwr_addr", 32'(obs_addr), 32'h0000_0FFF);
        check("memwr_we", 32'(obs_we), 32'd1);
        check("memwr_wdata", obs_wdata, 32'h1234_5678);

        // LED write then read back
        xfer(32'hFFFF_0000, 1'b1, 32'h0001_A5A5, rd, er, lat);
        check("led_wr_err", 32'(er), 32'd0);
        check("led_wr_lat", 32'(lat), 32'd2);
        check("led_value", 32'(led), 32'h0000_A5A5);
        xfer(32'hFFFF_0000, 1'b0, 32'd0, rd, er, lat);
        check("led_rd_data", rd, 32'h0000_A5A5);

        // Decode errors: misaligned then unmapped; memory never strobed
        en_before = mem_en_cycles;
        xfer(32'h0000_0002, 1'b0, 32'd0, rd, er, lat);
        check("misal_err", 32'(er), 32'd1);
        check("misal_data", rd, 32'd0);
        check("misal_lat", 32'(lat), 32'd1);
        xfer(32'h8000_0000, 1'b0, 32'd0, rd, er, lat);
        check("unmap_err", 32'(er), 32'd1);
        check("unmap_lat", 32'(lat), 32'd1);
        check("err_no_mem_en", 32'(mem_en_cycles - en_before), 32'd0);
        xfer(32'hFFFF_0008, 1'b0, 32'd0, rd, er, lat);
        check("status_2", rd, 32'd2);
        check("status_2_err", 32'(er), 32'd0);

        // Timer: clear, wait 10 cycles, read. Clear edge ends the REG cycle;
        // the read's REG cycle is 13 edges later (RESP, GAP, 10 waits, IDLE).
        xfer(32'hFFFF_0004, 1'b1, 32'h7777_7777, rd, er, lat);
        repeat (10) @(negedge clk);
        xfer(32'hFFFF_0004, 1'b0, 32'd0, rd, er, lat);
        check("timer_dist", rd, 32'd13);

        // Reserved offset and ignored STATUS write
        xfer(32'hFFFF_000C, 1'b0, 32'd0, rd, er, lat);
        check("rsvd_data", rd, 32'd0);
        check("rsvd_err", 32'(er), 32'd0);
        xfer(32'hFFFF_0008, 1'b1, 32'h0000_00FF, rd, er, lat);
        check("status_wr_err", 32'(er), 32'd0);

        // Window boundaries just outside memory and MMIO
        en_before = mem_en_cycles;
        xfer(32'h0000_4000, 1'b0, 32'd0, rd, er, lat);
        check("mem_end_err", 32'(er), 32'd1);
        xfer(32'hFFFF_0010, 1'b0, 32'd0, rd, er, lat);
        check("mmio_end_err", 32'(er), 32'd1);
        check("bound_no_mem_en", 32'(mem_en_cycles - en_before), 32'd0);
        xfer(32'hFFFF_0008, 1'b0, 32'd0, rd, er, lat);
        check("status_4", rd, 32'd4);

`ifdef BC_TIMEOUT_EN
        // Watchdog: no ack, abort after 16 MEM cycles
        ack_enable = 1'b0;
        xfer(32'h0000_0040, 1'b0, 32'd0, rd, er, lat);
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_data", rd, 32'd0);
        check("tmo_lat", 32'(lat), 32'd17);
        ack_enable = 1'b1;
        xfer(32'hFFFF_0008, 1'b0, 32'd0, rd, er, lat);
        check("tmo_status", rd, 32'd5);
`endif

        // Reset in the middle of a memory write
        ack_enable = 1'b0;
        @(negedge clk);
        cpu_bc_req  = 1'b1;
        cpu_bc_addr = 32'h0000_0020;
        cpu_bc_rw   = 1'b1;
        cpu_bc_data = 32'h0000_0055;
        @(negedge clk);
        check("abort_en_before", {30'd0, mem_en, mem_we}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("abort_en_now", {30'd0, mem_en, mem_we}, 32'd0);
        check("abort_led", 32'(led), 32'd0);
        @(negedge clk);
        cpu_bc_req = 1'b0;
        cpu_bc_rw  = 1'b0;
        rst        = 1'b0;
        n_ready = 0;
        repeat (6) begin
            @(negedge clk);
            if (bc_cpu_ready) n_ready++;
        end
        check("abort_no_ready", 32'(n_ready), 32'd0);
        ack_enable = 1'b1;
        xfer(32'hFFFF_0008, 1'b0, 32'd0, rd, er, lat);
        check("abort_status", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_bus_ctrl_resp
